pll_lock_supervisor: RTL and testbench

//  Supervises a Gowin PLLA instance (TMDS/pixel clock generator) from the reference clock domain.
//  - Drives PLL RESET, qualifies LOCK with a debounce window and a lock timeout, and retries on failure.
//  - Releases N per-domain resets in a fixed staggered order once lock is stable.
//  - On loss of lock, re-asserts all domain resets and re-runs the sequence.

---
 rtl/pll_sup_pkg.sv | 26 ++
 rtl/pll_sup_sync.sv | 38 +++
 rtl/pll_lock_supervisor.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and constants for the PLL lock supervisor.
//   state_e   : supervisor FSM encoding, also exported on state_o when the
//               PLL_LOCK_SUPERVISOR_STATS_EN build option is defined
//   STATE_W   : width of the state encoding
//   RELOCK_W  : width of the relock statistics counter
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  localparam int STATE_W  = 3;
  localparam int RELOCK_W = 8;

  typedef enum logic [STATE_W-1:0] {
    PLLRST    = 3'd0,  // PLL held in reset for a fixed pulse
    WAIT_LOCK = 3'd1,  // waiting for the synchronised lock to go high
    STABLE    = 3'd2,  // lock high, debouncing
    RELEASE   = 3'd3,  // staggered release of the domain resets
    RUN       = 3'd4,  // all domains released
    FAIL      = 3'd5   // retries exhausted, terminal until rst_n
  } state_e;

  // Saturation ceiling of the relock counter.
  localparam logic [RELOCK_W-1:0] RELOCK_MAX = {RELOCK_W{1'b1}};

endpackage : pll_sup_pkg

// File: rtl/pll_sup_sync.sv
// -----------------------------------------------------------------------------
// pll_sup_sync
// Plain multi-flop synchroniser for a single asynchronous level signal.
// The output is the input delayed by STAGES clk_i flops; every flop resets
// to 0, so a raw lock that is already high is still seen as low until it has
// propagated through the chain after reset release.
// Ports:
//   clk_i   in  1  destination clock
//   rst_ni  in  1  asynchronous active-low reset
//   d_i     in  1  asynchronous input
//   q_o     out 1  synchronised output
// -----------------------------------------------------------------------------
module pll_sup_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Bit 0 captures the raw input, the MSB is the synchronised output.
  assign sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : pll_sup_sync

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Supervises a PLLA instance from the reference clock domain: pulses the PLL
// reset, debounces LOCK, enforces a lock timeout with a bounded number of
// retries, and releases N downstream domain resets in a fixed staggered order.
// Any loss of lock after release re-asserts every domain reset at once and
// restarts the whole sequence.
//
// Ports:
//   clkin       in  1          reference clock
//   rst_n       in  1          asynchronous active-low reset
//   pll_lock    in  1          raw PLL LOCK, asynchronous to clkin
//   pll_reset   out 1          PLL RESET, active high
//   dom_rst_n   out N_DOMAINS  per-domain resets, active low (clkin domain)
//   ready       out 1          all domains released and lock stable
//   fail        out 1          lock attempts exhausted
//   relock_cnt  out 8          (PLL_LOCK_SUPERVISOR_STATS_EN only) lock-loss
//                              events after release, saturating
//   state_o     out 3          (PLL_LOCK_SUPERVISOR_STATS_EN only) FSM state
//
// Build option: define PLL_LOCK_SUPERVISOR_STATS_EN to add the statistics
// ports and the relock counter. Without it behaviour is otherwise identical.
//
// Handshake note: there is no valid/ready transfer here. pll_lock is a level
// that is only trusted after synchronisation; ready is a level that stays
// high for as long as the supervisor is in RUN.
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_DOMAINS        = 3,
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RST_CYC      = 64,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int STAGGER_CYC      = 16,
  parameter int MAX_RETRY        = 4
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  output logic                 pll_reset,
  output logic [N_DOMAINS-1:0] dom_rst_n,
  output logic                 ready,
  output logic                 fail
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
  ,
  output logic [RELOCK_W-1:0]  relock_cnt,
  output logic [STATE_W-1:0]   state_o
`endif
);

  // ---------------------------------------------------------------------------
  // Counter widths and terminal values. Each counter can represent its
  // parameter value, so saturation never needs a wrap.
  // ---------------------------------------------------------------------------
  localparam int REL_CYC = STAGGER_CYC * N_DOMAINS;
  localparam int RST_W   = $clog2(PLL_RST_CYC + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int REL_W   = $clog2(REL_CYC + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYC - 1);
  localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(LOCK_TIMEOUT_CYC);
  localparam logic [REL_W-1:0] REL_DONE = REL_W'(REL_CYC);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  // ---------------------------------------------------------------------------
  // Lock synchroniser: every decision below uses lock_s only.
  // ---------------------------------------------------------------------------
  logic lock_s;

  pll_sup_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clkin),
    .rst_ni (rst_n),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e               state_q,     state_d;
  logic [RST_W-1:0]     rst_cnt_q,   rst_cnt_d;
  logic [STB_W-1:0]     stb_cnt_q,   stb_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q,   tmo_cnt_d;
  logic [REL_W-1:0]     rel_cnt_q,   rel_cnt_d;
  logic [RTY_W-1:0]     rty_cnt_q,   rty_cnt_d;
  logic                 pll_reset_q, pll_reset_d;
  logic [N_DOMAINS-1:0] dom_q,       dom_d;
  logic                 ready_q,     ready_d;
  logic                 fail_q,      fail_d;

  // Saturating increments of the free-running counters.
  logic [STB_W-1:0] stb_inc;
  logic [TMO_W-1:0] tmo_inc;
  logic [REL_W-1:0] rel_inc;
  logic [RTY_W-1:0] rty_inc;

  // Lock dropped after the domains started coming out of reset.
  logic lock_loss;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLLRST;
      rst_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      rty_cnt_q   <= '0;
      pll_reset_q <= 1'b1;
      dom_q       <= '0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      rty_cnt_q   <= rty_cnt_d;
      pll_reset_q <= pll_reset_d;
      dom_q       <= dom_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    rty_cnt_d   = rty_cnt_q;
    pll_reset_d = pll_reset_q;
    dom_d       = dom_q;
    ready_d     = ready_q;
    fail_d      = fail_q;
    lock_loss   = 1'b0;

    stb_inc = (stb_cnt_q == STB_DONE) ? stb_cnt_q : stb_cnt_q + 1'b1;
    tmo_inc = (tmo_cnt_q == TMO_SAT)  ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    rel_inc = (rel_cnt_q == REL_DONE) ? rel_cnt_q : rel_cnt_q + 1'b1;
    rty_inc = (rty_cnt_q == RTY_MAX)  ? rty_cnt_q : rty_cnt_q + 1'b1;

    case (state_q)
      PLLRST: begin
        pll_reset_d = 1'b1;
        dom_d       = '0;
        ready_d     = 1'b0;
        if (rst_cnt_q == RST_LAST) begin
          // Pulse complete: release the PLL and start the lock timeout on
          // the same edge.
          state_d     = WAIT_LOCK;
          pll_reset_d = 1'b0;
          rst_cnt_d   = '0;
          tmo_cnt_d   = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      WAIT_LOCK, STABLE: begin
        // The timeout spans both states so a flapping lock cannot keep the
        // supervisor waiting forever; it also outranks a debounce completion
        // landing on the same cycle.
        tmo_cnt_d = tmo_inc;
        if (tmo_cnt_q == TMO_LAST) begin
          rty_cnt_d   = rty_inc;
          pll_reset_d = 1'b1;
          rst_cnt_d   = '0;
          stb_cnt_d   = '0;
          if (rty_inc == RTY_MAX) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = PLLRST;
          end
        end else if (state_q == WAIT_LOCK) begin
          if (lock_s) begin
            state_d   = STABLE;
            stb_cnt_d = '0;
          end
        end else if (!lock_s) begin
          // Glitch: restart the debounce, keep the timeout running.
          state_d   = WAIT_LOCK;
          stb_cnt_d = '0;
        end else begin
          stb_cnt_d = stb_inc;
          if (stb_inc == STB_DONE) begin
            state_d   = RELEASE;
            rel_cnt_d = '0;
          end
        end
      end

      RELEASE: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else begin
          rel_cnt_d = rel_inc;
          // Bits only ever set here, so release order is strictly 0..N-1.
          for (int i = 0; i < N_DOMAINS; i++) begin
            if (rel_inc == REL_W'(STAGGER_CYC * (i + 1))) begin
              dom_d[i] = 1'b1;
            end
          end
          if (rel_inc == REL_DONE) begin
            state_d   = RUN;
            ready_d   = 1'b1;
            rty_cnt_d = '0;
          end
        end
      end

      RUN: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end
      end

      FAIL: begin
        pll_reset_d = 1'b1;
        dom_d       = '0;
        ready_d     = 1'b0;
        fail_d      = 1'b1;
      end

      default: begin
        state_d     = PLLRST;
        rst_cnt_d   = '0;
        pll_reset_d = 1'b1;
        dom_d       = '0;
        ready_d     = 1'b0;
      end
    endcase

    // All domains drop together on the edge after the loss is seen, which
    // is what keeps already-released domains from deasserting out of order.
    if (lock_loss) begin
      state_d     = PLLRST;
      rst_cnt_d   = '0;
      pll_reset_d = 1'b1;
      dom_d       = '0;
      ready_d     = 1'b0;
    end
  end

  assign pll_reset = pll_reset_q;
  assign dom_rst_n = dom_q;
  assign ready     = ready_q;
  assign fail      = fail_q;

`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
  // ---------------------------------------------------------------------------
  // Relock statistics: counts lock losses after release, cleared only by rst_n.
  // ---------------------------------------------------------------------------
  logic [RELOCK_W-1:0] relock_q, relock_d;

  always_comb begin
    relock_d = relock_q;
    if (lock_loss && (relock_q != RELOCK_MAX)) begin
      relock_d = relock_q + 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_cnt = relock_q;
  assign state_o    = state_q;
`endif

endmodule : pll_lock_supervisor

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with small timing parameters.
// Stimulus pushes {cycle, value} entries for every expected change of the
// observed output vector {fail, ready, pll_reset, dom_rst_n[2:0]}; a monitor
// samples on the falling edge and pops/compares an entry whenever the vector
// changes. Cycle numbers are counts of rising clkin edges.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int OW = 6;
  localparam int W  = 32 + OW;
  // {fail, ready, pll_reset, dom_rst_n}
  localparam logic [OW-1:0] RST_VAL  = 6'b001_000;
  localparam logic [OW-1:0] PLL_GO   = 6'b000_000;
  localparam logic [OW-1:0] DOM0     = 6'b000_001;
  localparam logic [OW-1:0] DOM01    = 6'b000_011;
  localparam logic [OW-1:0] RUN_VAL  = 6'b010_111;
  localparam logic [OW-1:0] FAIL_VAL = 6'b101_000;

  // ---------------------------------------------------------------- clock/reset
  logic       clkin    = 1'b0;
  logic       rst_n    = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [2:0] dom_rst_n;
  logic       ready;
  logic       fail;
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
  logic [7:0] relock_cnt;
  logic [2:0] state_o;
`endif

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  pll_lock_supervisor #(
    .N_DOMAINS        (3),
    .SYNC_STAGES      (2),
    .PLL_RST_CYC      (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (100),
    .STAGGER_CYC      (3),
    .MAX_RETRY        (2)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .dom_rst_n  (dom_rst_n),
    .ready      (ready),
    .fail       (fail)
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    ,
    .relock_cnt (relock_cnt),
    .state_o    (state_o)
`endif
  );

  logic [OW-1:0] obs;
  assign obs = {fail, ready, pll_reset, dom_rst_n};

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic expect_at(input int c, input logic [OW-1:0] v);
    exp_q.push_back({32'(c), v});
  endtask

  // Monitor: every change of the observed vector while out of reset must
  // match the next expected entry in both value and cycle.
  initial begin
    logic [OW-1:0] prev;
    logic [OW-1:0] cur;
    logic [W-1:0]  e;
    prev = RST_VAL;
    forever begin
      @(negedge clkin);
      if (!rst_n) begin
        prev = RST_VAL;
      end else begin
        cur = obs;
        if (cur !== prev) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_change: cycle %0d got %b, want no change from %b",
                     cyc, cur, prev);
          end else begin
            e = exp_q.pop_front();
            if ((cur === e[OW-1:0]) && (cyc == int'(e[W-1:OW])))
              n_pass++;
            else
              $display("FAIL output_event: cycle %0d value %b, want cycle %0d value %b",
                       cyc, cur, int'(e[W-1:OW]), e[OW-1:0]);
          end
          prev = cur;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Advance n rising edges and settle 2 time units past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clkin);
    #2;
  endtask

  // Reset pulse; returns the cycle count of the edge just before release.
  task automatic do_reset(input logic lock_v, output int anchor);
    rst_n    = 1'b0;
    pll_lock = lock_v;
    edges(2);
    check("reset_state", {2'b00, obs}, {2'b00, RST_VAL});
    edges(1);
    rst_n  = 1'b1;
    anchor = cyc;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int a, b, c;
    logic [W-1:0] e;

    edges(1);

    // 1. Clean start, lock from cycle 10. lock_s high after a+12, STABLE
    //    entered at a+13, debounce done at a+21, releases at +3/+6/+9.
    do_reset(1'b0, a);
    expect_at(a + 4,  PLL_GO);
    expect_at(a + 24, DOM0);
    expect_at(a + 27, DOM01);
    expect_at(a + 30, RUN_VAL);
    edges(10);
    pll_lock = 1'b1;
    edges(25);

    // 4. Lock loss in RUN: 2 sync flops + 1 edge, then a new 4-cycle pulse,
    //    and relock after b+10 repeats the release 11+3/6/9 cycles later.
    b = cyc;
    pll_lock = 1'b0;
    expect_at(b + 3, RST_VAL);
    expect_at(b + 7, PLL_GO);
    edges(10);
    c = cyc;
    pll_lock = 1'b1;
    expect_at(c + 14, DOM0);
    expect_at(c + 17, DOM01);
    expect_at(c + 20, RUN_VAL);
    edges(25);
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    check("relock_cnt", relock_cnt, 8'd1);
    check("state_run", {5'b0, state_o}, 8'd4);
`endif

    // 6. Async reset in RUN: outputs return without a clock edge.
    check("run_before_reset", {2'b00, obs}, {2'b00, RUN_VAL});
    rst_n = 1'b0;
    #1;
    check("async_reset", {2'b00, obs}, {2'b00, RST_VAL});

    // 2. Lock glitch: lock present from release, STABLE entered at a+5.
    //    lock_s is low only in the cycle that would have taken the count to 5,
    //    so debounce restarts at a+11 and completes at a+19 instead of a+13.
    do_reset(1'b1, a);
    expect_at(a + 4,  PLL_GO);
    expect_at(a + 22, DOM0);
    expect_at(a + 25, DOM01);
    expect_at(a + 28, RUN_VAL);
    edges(7);
    pll_lock = 1'b0;
    edges(1);
    pll_lock = 1'b1;
    edges(30);

    // 5. Lock loss mid-RELEASE: RELEASE from a+13, dom0 at a+16, loss seen
    //    at a+19 (the edge dom1 would have risen) -> all resets drop.
    do_reset(1'b1, a);
    expect_at(a + 4,  PLL_GO);
    expect_at(a + 16, DOM0);
    expect_at(a + 19, RST_VAL);
    expect_at(a + 23, PLL_GO);
    edges(16);
    pll_lock = 1'b0;
    edges(30);

    // 3. No lock at all: timeout 100 cycles after each release, second
    //    timeout exhausts MAX_RETRY=2 and lands in FAIL.
    do_reset(1'b0, a);
    expect_at(a + 4,   PLL_GO);
    expect_at(a + 104, RST_VAL);
    expect_at(a + 108, PLL_GO);
    expect_at(a + 208, FAIL_VAL);
    edges(240);
    check("fail_hold", {2'b00, obs}, {2'b00, FAIL_VAL});

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_event: got no change, want cycle %0d value %b",
               int'(e[W-1:OW]), e[OW-1:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pll_lock_supervisor
